encrypt_store_unit: RTL and testbench

Parametrised, multi-cycle successor to the rotate/multiply/store encryption datapath. It accepts a plaintext operand and key under a start/busy/done handshake, and rotates the operand right by a fixed amount. It multiplies the rotated operand by the key using a sequential shift-add multiplier (one partial-product step per clock). The 2*WIDTH-bit product goes into an internal buffer at an auto-incrementing address, and a separate synchronous port reads the buffer back. The unit sits between operand capture and downstream readout in the encryption datapath.

---
 rtl/encrypt_store_unit.sv | 131 +++++++++++++
 tb/tb_encrypt_store_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_store_unit.sv
// Rotate/multiply/store encryption datapath: sequential shift-add multiply of
// the rotated operand by the key, products stored in a buffer with a read port.
module encrypt_store_unit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ROT       = 2,
  parameter int unsigned OVERWRITE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     num,
  input  logic [WIDTH-1:0]     key,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 refused,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned RSH   = ROT % WIDTH;
  localparam int unsigned IW    = $clog2(WIDTH + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, MULT, WRITE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q, a_q, q_q;
  logic [IW-1:0]        iter_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [ADDR_W:0]      count_q;
  logic                 busy_q, done_q, refused_q;
  logic [2*WIDTH-1:0]   rd_data_q;
  logic [2*WIDTH-1:0]   mem [DEPTH];

  logic [WIDTH-1:0]     rot_num;
  logic [WIDTH:0]       sum;
  logic                 full_w, refuse_w;

  always_comb begin
    rot_num = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rot_num[i] = num[(i + RSH) % WIDTH];
    end
    sum = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q}) : {1'b0, a_q};
  end

  assign full_w   = (count_q == DEPTH_C);
  assign refuse_w = full_w && (OVERWRITE == 0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      iter_q    <= '0;
      wr_addr_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      refused_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      refused_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (refuse_w) begin
              refused_q <= 1'b1;
            end else begin
              m_q     <= rot_num;
              q_q     <= key;
              a_q     <= '0;
              iter_q  <= IW'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= MULT;
            end
          end
        end
        MULT: begin
          // Carry lands in A's MSB on the shift, so no separate C register is kept.
          a_q    <= sum[WIDTH:1];
          q_q    <= {sum[0], q_q[WIDTH-1:1]};
          iter_q <= iter_q - IW'(1);
          if (iter_q == IW'(1)) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
          if (!full_w) begin
            count_q <= count_q + (ADDR_W + 1)'(1);
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clock) begin
    if (state_q == WRITE) begin
      mem[wr_addr_q] <= {a_q, q_q};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_addr = wr_addr_q;
  assign count   = count_q;
  assign full    = full_w;
  assign refused = refused_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_encrypt_store_unit.sv
// Directed bench for encrypt_store_unit with a product scoreboard; runs an
// OVERWRITE=1 and an OVERWRITE=0 instance side by side on shared stimulus.
module tb_encrypt_store_unit;

  localparam int W = 4;
  localparam int AW = 4;
  localparam int R = 2;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  num = '0, key = '0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy, done, full, refused;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   count;
  logic [2*W-1:0] rd_data;
  logic          busy_b, done_b, full_b, refused_b;
  logic [AW-1:0] wr_addr_b;
  logic [AW:0]   count_b;
  logic [2*W-1:0] rd_data_b;

  encrypt_store_unit #(.WIDTH(W), .ADDR_W(AW), .ROT(R), .OVERWRITE(1)) dut (
    .clock(clock), .reset(reset), .start(start), .num(num), .key(key),
    .busy(busy), .done(done), .wr_addr(wr_addr), .count(count), .full(full),
    .refused(refused), .rd_addr(rd_addr), .rd_data(rd_data));

  encrypt_store_unit #(.WIDTH(W), .ADDR_W(AW), .ROT(R), .OVERWRITE(0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .num(num), .key(key),
    .busy(busy_b), .done(done_b), .wr_addr(wr_addr_b), .count(count_b), .full(full_b),
    .refused(refused_b), .rd_addr(rd_addr), .rd_data(rd_data_b));

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [2*W-1:0] data;
  } exp_t;

  exp_t           exp_q[$];
  logic [2*W-1:0] model_mem [DEPTH];
  int             m_wr = 0;
  int             m_count = 0;
  int             checks = 0;
  int             errors = 0;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v);
    int x;
    x = int'(v);
    return W'(((x >> R) | (x << (W - R))) & ((1 << W) - 1));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [W-1:0] n, input logic [W-1:0] k);
    exp_t e;
    e.addr = AW'(m_wr);
    e.data = (2*W)'(int'(rotr(n)) * int'(k));
    exp_q.push_back(e);
    m_wr = (m_wr + 1) % DEPTH;
  endtask

  task automatic pop_check();
    exp_t e;
    e = exp_q.pop_front();
    model_mem[e.addr] = e.data;
    if (m_count < DEPTH) m_count++;
    check("wr_addr_after_done", wr_addr, (int'(e.addr) + 1) % DEPTH);
    check("count_after_done", count, m_count);
    check("full_after_done", full, m_count == DEPTH);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    if (done === 1'b1 && exp_q.size() > 0) pop_check();
  endtask

  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] k);
    int lat;
    start = 1'b1; num = n; key = k;
    tick();
    start = 1'b0;
    push_op(n, k);
    wait_done(lat);
    check("op_latency", lat, W + 1);
  endtask

  task automatic read_check(input int addr);
    rd_addr = AW'(addr);
    tick();
    check("rd_data", rd_data, model_mem[addr]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_wr = 0;
    m_count = 0;
  endtask

  initial begin : main
    int n;
    logic [2*W-1:0] old_v;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_refused", refused, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();

    // Single operation, cycle-by-cycle
    num = 4'b1000; key = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    push_op(4'b1000, 4'b1000);
    check("t1_busy_e0", busy, 1);
    check("t1_done_e0", done, 0);
    for (int i = 1; i <= W; i++) begin
      tick();
      check("t1_busy_mult", busy, 1);
      check("t1_done_mult", done, 0);
    end
    tick();
    check("t1_done_pulse", done, 1);
    check("t1_busy_low", busy, 0);
    pop_check();
    tick();
    check("t1_done_one_cycle", done, 0);
    read_check(0);

    // Back-to-back issue in the done cycle
    do_reset();
    run_op(4'b1001, 4'b1000);
    run_op(4'b1100, 4'b1010);
    run_op(4'b1011, 4'b1110);
    check("b2b_count", count, 3);
    check("b2b_wr_addr", wr_addr, 3);
    read_check(0);
    read_check(1);
    read_check(2);

    // start during MULT is ignored
    num = 4'b0011; key = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    push_op(4'b0011, 4'b0101);
    tick(); tick();
    num = 4'b1111; key = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", n, 2);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ignore_no_done", done, 0);
      check("ignore_no_busy", busy, 0);
    end
    read_check(3);

    // Fill the buffer
    for (int i = 0; i < 20 && m_count < DEPTH; i++) begin
      run_op(W'(i + 2), W'(i * 3 + 1));
    end
    check("fill_full", full, 1);
    check("fill_full_b", full_b, 1);
    check("fill_wr_addr", wr_addr, 0);

    // 17th operation: overwrite vs refuse
    old_v = model_mem[0];
    num = 4'b0001; key = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    push_op(4'b0001, 4'b0011);
    check("ovf_busy", busy, 1);
    check("ref_pulse", refused_b, 1);
    check("ref_no_busy", busy_b, 0);
    check("ovf_no_refuse", refused, 0);
    tick();
    check("ref_one_cycle", refused_b, 0);
    check("ref_still_idle", busy_b, 0);
    wait_done(n);
    check("ovf_count", count, DEPTH);
    check("ref_count", count_b, DEPTH);
    check("ref_wr_addr", wr_addr_b, 0);
    rd_addr = '0;
    tick();
    check("ovf_addr0", rd_data, model_mem[0]);
    check("ref_addr0_kept", rd_data_b, old_v);

    // Read/write collision
    old_v = model_mem[m_wr];
    n = m_wr;
    rd_addr = AW'(m_wr);
    run_op(4'b0110, 4'b1101);
    check("coll_old", rd_data, old_v);
    tick();
    check("coll_new", rd_data, model_mem[n]);

    // Reset mid-MULT aborts the operation
    n = m_wr;
    old_v = model_mem[n];
    num = 4'b0101; key = 4'b0111; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", count, 0);
    check("abort_wr_addr", wr_addr, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_wr = 0;
    m_count = 0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_no_done", done, 0);
    end
    rd_addr = AW'(n);
    tick();
    check("abort_no_write", rd_data, old_v);
    run_op(4'b0110, 4'b0101);
    read_check(0);
    check("post_abort_count_b", count_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
